// File: rtl/ysyx_23060111_trap_ctrl.sv
// CSR/trap sequencer: runs CSRRW/CSRRS/ECALL/MRET one at a time against the register/CSR file.
// Optional mstatus field handling on trap/return: `define YSYX_23060111_MSTATUS_FIELDS_EN.
module ysyx_23060111_trap_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [1:0]            req_csr,
  input  logic [DATA_WIDTH-1:0] req_src,
  input  logic [DATA_WIDTH-1:0] req_pc,
  input  logic [DATA_WIDTH-1:0] csr_rout,
  input  logic [DATA_WIDTH-1:0] csrr_mtvec,
  input  logic [DATA_WIDTH-1:0] csrr_mepc,
  input  logic [DATA_WIDTH-1:0] csrr_mstatus,
  output logic [1:0]            csr_raddr,
  output logic                  csr_wen,
  output logic [1:0]            csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_mepc_wen,
  output logic [DATA_WIDTH-1:0] csr_mepc_wdata,
  output logic                  csr_mcause_wen,
  output logic [DATA_WIDTH-1:0] csr_mcause_wdata,
  output logic                  csrr_mstatus_wen,
  output logic [DATA_WIDTH-1:0] csr_mstatus_wdata,
  output logic                  rd_wen,
  output logic [DATA_WIDTH-1:0] rd_wdata,
  output logic                  redir_valid,
  output logic [DATA_WIDTH-1:0] redir_pc,
  output logic                  done_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_TRAP,
    S_RET,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_CSRRW = 2'b00,
    OP_CSRRS = 2'b01,
    OP_ECALL = 2'b10,
    OP_MRET  = 2'b11
  } op_t;

  state_t                r_state;
  op_t                   r_op;
  logic [1:0]            r_csr;
  logic [DATA_WIDTH-1:0] r_src;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_old;
  logic                  r_req_ready;
  logic                  r_csr_wen;
  logic [DATA_WIDTH-1:0] r_csr_wdata;
  logic                  r_rd_wen;
  logic                  r_mepc_wen;
  logic                  r_mcause_wen;
  logic                  r_redir_valid;
  logic [DATA_WIDTH-1:0] r_redir_pc;
  logic                  r_done_valid;

  // Outputs are registered one state ahead: each is set on the edge that enters the state
  // which owns it, so it is valid for exactly that state's cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= OP_CSRRW;
      r_csr         <= '0;
      r_src         <= '0;
      r_pc          <= '0;
      r_old         <= '0;
      r_req_ready   <= 1'b1;
      r_csr_wen     <= 1'b0;
      r_csr_wdata   <= '0;
      r_rd_wen      <= 1'b0;
      r_mepc_wen    <= 1'b0;
      r_mcause_wen  <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
      r_done_valid  <= 1'b0;
    end else begin
      r_req_ready   <= 1'b0;
      r_csr_wen     <= 1'b0;
      r_rd_wen      <= 1'b0;
      r_mepc_wen    <= 1'b0;
      r_mcause_wen  <= 1'b0;
      r_redir_valid <= 1'b0;
      r_done_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op  <= op_t'(req_op);
            r_csr <= req_csr;
            r_src <= req_src;
            r_pc  <= req_pc;
            case (op_t'(req_op))
              OP_ECALL: begin
                r_state       <= S_TRAP;
                r_mepc_wen    <= 1'b1;
                r_mcause_wen  <= 1'b1;
                r_redir_valid <= 1'b1;
                r_redir_pc    <= {csrr_mtvec[DATA_WIDTH-1:2], 2'b00};
              end
              OP_MRET: begin
                r_state       <= S_RET;
                r_redir_valid <= 1'b1;
                r_redir_pc    <= csrr_mepc;
              end
              default: r_state <= S_READ;
            endcase
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_READ: begin
          r_state  <= S_WRITE;
          r_old    <= csr_rout;
          r_rd_wen <= 1'b1;
          if (r_op == OP_CSRRW) begin
            r_csr_wen   <= 1'b1;
            r_csr_wdata <= r_src;
          end else begin
            r_csr_wen   <= (r_src != '0);
            r_csr_wdata <= csr_rout | r_src;
          end
        end
        S_WRITE, S_TRAP, S_RET: begin
          r_state      <= S_DONE;
          r_done_valid <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Enables are also masked by rst so a reset landing mid-WRITE/TRAP/RET commits nothing.
  assign req_ready        = r_req_ready;
  assign csr_raddr        = r_csr;
  assign csr_wen          = r_csr_wen & ~rst;
  assign csr_waddr        = r_csr;
  assign csr_wdata        = r_csr_wdata;
  assign csr_mepc_wen     = r_mepc_wen & ~rst;
  assign csr_mepc_wdata   = r_pc;
  assign csr_mcause_wen   = r_mcause_wen & ~rst;
  assign csr_mcause_wdata = DATA_WIDTH'(11);
  assign rd_wen           = r_rd_wen & ~rst;
  assign rd_wdata         = r_old;
  assign redir_valid      = r_redir_valid & ~rst;
  assign redir_pc         = r_redir_pc;
  assign done_valid       = r_done_valid & ~rst;

`ifdef YSYX_23060111_MSTATUS_FIELDS_EN
  logic                  r_mst_wen;
  logic [DATA_WIDTH-1:0] r_mst_wdata;
  logic [1:0]            w_unused;

  function automatic logic [DATA_WIDTH-1:0] f_trap_mst(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] v;
    v        = s;
    v[7]     = s[3];
    v[3]     = 1'b0;
    v[12:11] = 2'b11;
    return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_ret_mst(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] v;
    v        = s;
    v[3]     = s[7];
    v[7]     = 1'b1;
    v[12:11] = 2'b00;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mst_wen   <= 1'b0;
      r_mst_wdata <= '0;
    end else begin
      r_mst_wen <= 1'b0;
      if (r_state == S_IDLE && req_valid) begin
        if (op_t'(req_op) == OP_ECALL) begin
          r_mst_wen   <= 1'b1;
          r_mst_wdata <= f_trap_mst(csrr_mstatus);
        end else if (op_t'(req_op) == OP_MRET) begin
          r_mst_wen   <= 1'b1;
          r_mst_wdata <= f_ret_mst(csrr_mstatus);
        end
      end
    end
  end

  assign csrr_mstatus_wen  = r_mst_wen & ~rst;
  assign csr_mstatus_wdata = r_mst_wdata;
  assign w_unused          = csrr_mtvec[1:0];
`else
  logic w_unused;

  assign csrr_mstatus_wen  = 1'b0;
  assign csr_mstatus_wdata = '0;
  assign w_unused          = ^{csrr_mtvec[1:0], csrr_mstatus};
`endif

endmodule

// File: tb/tb_ysyx_23060111_trap_ctrl.sv
// Bench for ysyx_23060111_trap_ctrl: vector table of single ops against a small CSR file model,
// plus hand sequences for back-to-back requests and reset during WRITE.
module tb_ysyx_23060111_trap_ctrl;
  localparam int W = 32;

`ifdef YSYX_23060111_MSTATUS_FIELDS_EN
  localparam bit MST_EN = 1'b1;
`else
  localparam bit MST_EN = 1'b0;
`endif
  localparam logic [31:0] ECALL_MST_A = MST_EN ? 32'h0000_1880 : 32'h0000_0008;
  localparam logic [31:0] ECALL_MST_B = MST_EN ? 32'h0000_1800 : 32'h0000_0000;
  localparam logic [31:0] MRET_MST    = MST_EN ? 32'h0000_0088 : 32'h0000_1880;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [1:0]   req_csr;
  logic [W-1:0] req_src;
  logic [W-1:0] req_pc;
  logic [W-1:0] csr_rout;
  logic [W-1:0] csrr_mtvec;
  logic [W-1:0] csrr_mepc;
  logic [W-1:0] csrr_mstatus;
  logic [1:0]   csr_raddr;
  logic         csr_wen;
  logic [1:0]   csr_waddr;
  logic [W-1:0] csr_wdata;
  logic         csr_mepc_wen;
  logic [W-1:0] csr_mepc_wdata;
  logic         csr_mcause_wen;
  logic [W-1:0] csr_mcause_wdata;
  logic         csrr_mstatus_wen;
  logic [W-1:0] csr_mstatus_wdata;
  logic         rd_wen;
  logic [W-1:0] rd_wdata;
  logic         redir_valid;
  logic [W-1:0] redir_pc;
  logic         done_valid;

  always #5 clk = ~clk;

  ysyx_23060111_trap_ctrl #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_csr(req_csr),
    .req_src(req_src), .req_pc(req_pc),
    .csr_rout(csr_rout), .csrr_mtvec(csrr_mtvec), .csrr_mepc(csrr_mepc), .csrr_mstatus(csrr_mstatus),
    .csr_raddr(csr_raddr), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_mepc_wen(csr_mepc_wen), .csr_mepc_wdata(csr_mepc_wdata),
    .csr_mcause_wen(csr_mcause_wen), .csr_mcause_wdata(csr_mcause_wdata),
    .csrr_mstatus_wen(csrr_mstatus_wen), .csr_mstatus_wdata(csr_mstatus_wdata),
    .rd_wen(rd_wen), .rd_wdata(rd_wdata),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .done_valid(done_valid)
  );

  // CSR file model: index 0 mepc, 1 mcause, 2 mstatus, 3 mtvec; {mtvec,mstatus,mcause,mepc} packed.
  logic [3:0][31:0] csr = '0;
  logic [3:0][31:0] ld  = '0;
  logic             load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      csr <= ld;
    end else begin
      if (csr_wen)          csr[csr_waddr] <= csr_wdata;
      if (csr_mepc_wen)     csr[0] <= csr_mepc_wdata;
      if (csr_mcause_wen)   csr[1] <= csr_mcause_wdata;
      if (csrr_mstatus_wen) csr[2] <= csr_mstatus_wdata;
    end
  end

  assign csr_rout     = csr[csr_raddr];
  assign csrr_mepc    = csr[0];
  assign csrr_mstatus = csr[2];
  assign csrr_mtvec   = csr[3];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic preload(input logic [3:0][31:0] v);
    @(negedge clk);
    ld   = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]       op;
    logic [1:0]       csr;
    logic [31:0]      src;
    logic [31:0]      pc;
    logic [3:0][31:0] init;
    logic [31:0]      exp_rd;
    logic             exp_wen;
    logic [31:0]      exp_wdata;
    logic [31:0]      exp_redir;
    logic [3:0][31:0] exp_csr;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int idx, input vec_t v);
    preload(v.init);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = v.op;
    req_csr   = v.csr;
    req_src   = v.src;
    req_pc    = v.pc;
    chk1($sformatf("v%0d_ready_idle", idx), req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.op[1] == 1'b0) begin
      chk($sformatf("v%0d_raddr", idx), {30'b0, csr_raddr}, {30'b0, v.csr});
      chk1($sformatf("v%0d_read_rdwen", idx), rd_wen, 1'b0);
      chk1($sformatf("v%0d_read_csrwen", idx), csr_wen, 1'b0);
      chk1($sformatf("v%0d_read_ready", idx), req_ready, 1'b0);
      @(negedge clk);
      chk1($sformatf("v%0d_write_rdwen", idx), rd_wen, 1'b1);
      chk($sformatf("v%0d_rd_wdata", idx), rd_wdata, v.exp_rd);
      chk1($sformatf("v%0d_csr_wen", idx), csr_wen, v.exp_wen);
      if (v.exp_wen) begin
        chk($sformatf("v%0d_waddr", idx), {30'b0, csr_waddr}, {30'b0, v.csr});
        chk($sformatf("v%0d_wdata", idx), csr_wdata, v.exp_wdata);
      end
      chk1($sformatf("v%0d_write_done", idx), done_valid, 1'b0);
      @(negedge clk);
      chk1($sformatf("v%0d_done", idx), done_valid, 1'b1);
      chk1($sformatf("v%0d_done_rdwen", idx), rd_wen, 1'b0);
      chk1($sformatf("v%0d_done_csrwen", idx), csr_wen, 1'b0);
    end else begin
      chk1($sformatf("v%0d_redir_valid", idx), redir_valid, 1'b1);
      chk($sformatf("v%0d_redir_pc", idx), redir_pc, v.exp_redir);
      chk1($sformatf("v%0d_mepc_wen", idx), csr_mepc_wen, ~v.op[0]);
      chk1($sformatf("v%0d_mcause_wen", idx), csr_mcause_wen, ~v.op[0]);
      chk1($sformatf("v%0d_mstatus_wen", idx), csrr_mstatus_wen, MST_EN);
      chk1($sformatf("v%0d_trap_csrwen", idx), csr_wen, 1'b0);
      chk1($sformatf("v%0d_trap_done", idx), done_valid, 1'b0);
      @(negedge clk);
      chk1($sformatf("v%0d_done", idx), done_valid, 1'b1);
      chk1($sformatf("v%0d_done_redir", idx), redir_valid, 1'b0);
      chk1($sformatf("v%0d_done_mepcwen", idx), csr_mepc_wen, 1'b0);
    end
    @(negedge clk);
    chk1($sformatf("v%0d_done_pulse", idx), done_valid, 1'b0);
    chk1($sformatf("v%0d_ready_back", idx), req_ready, 1'b1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("v%0d_csr%0d", idx, i), csr[i], v.exp_csr[i]);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_csr   = 2'b00;
    req_src   = '0;
    req_pc    = '0;

    //            op     csr    src            pc             init {mtvec,mstatus,mcause,mepc}
    //            exp_rd         wen   exp_wdata      exp_redir      exp_csr
    vecs[0] = '{2'd0, 2'd3, 32'h8000_0100, 32'h0, {32'h0, 32'h0, 32'h0, 32'h0},
                32'h0, 1'b1, 32'h8000_0100, 32'h0, {32'h8000_0100, 32'h0, 32'h0, 32'h0}};
    vecs[1] = '{2'd1, 2'd2, 32'h0, 32'h0, {32'h0, 32'h1800, 32'h0, 32'h0},
                32'h1800, 1'b0, 32'h0, 32'h0, {32'h0, 32'h1800, 32'h0, 32'h0}};
    vecs[2] = '{2'd2, 2'd0, 32'h0, 32'h8000_0040, {32'h8000_0101, 32'h8, 32'h0, 32'h0},
                32'h0, 1'b0, 32'h0, 32'h8000_0100, {32'h8000_0101, ECALL_MST_A, 32'hb, 32'h8000_0040}};
    vecs[3] = '{2'd3, 2'd0, 32'h0, 32'h0, {32'h0, 32'h1880, 32'h0, 32'h8000_0044},
                32'h0, 1'b0, 32'h0, 32'h8000_0044, {32'h0, MRET_MST, 32'h0, 32'h8000_0044}};
    vecs[4] = '{2'd1, 2'd1, 32'h5, 32'h0, {32'h0, 32'h0, 32'h30, 32'h0},
                32'h30, 1'b1, 32'h35, 32'h0, {32'h0, 32'h0, 32'h35, 32'h0}};
    vecs[5] = '{2'd0, 2'd0, 32'hdead_beef, 32'h0, {32'h0, 32'h0, 32'h0, 32'h1234_5678},
                32'h1234_5678, 1'b1, 32'hdead_beef, 32'h0, {32'h0, 32'h0, 32'h0, 32'hdead_beef}};
    vecs[6] = '{2'd1, 2'd3, 32'hf0, 32'h0, {32'hf, 32'h0, 32'h0, 32'h0},
                32'hf, 1'b1, 32'hff, 32'h0, {32'hff, 32'h0, 32'h0, 32'h0}};
    vecs[7] = '{2'd2, 2'd1, 32'h0, 32'h100, {32'h2003, 32'h0, 32'h7, 32'h0},
                32'h0, 1'b0, 32'h0, 32'h2000, {32'h2003, ECALL_MST_B, 32'hb, 32'h100}};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_rd_wen", rd_wen, 1'b0);
    chk1("rst_csr_wen", csr_wen, 1'b0);
    chk1("rst_mepc_wen", csr_mepc_wen, 1'b0);
    chk1("rst_mcause_wen", csr_mcause_wen, 1'b0);
    chk1("rst_mstatus_wen", csrr_mstatus_wen, 1'b0);
    chk1("rst_redir", redir_valid, 1'b0);
    chk1("rst_done", done_valid, 1'b0);
    chk("rst_rd_wdata", rd_wdata, 32'h0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Back-to-back CSRRW with req_valid held: second accepted only once IDLE again.
    preload({32'h0, 32'h0, 32'h0, 32'h7});
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_csr = 2'd0; req_src = 32'h1; req_pc = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk1($sformatf("b2b_csr_busy%0d", k), req_ready, 1'b0);
    end
    @(negedge clk);
    chk1("b2b_csr_ready4", req_ready, 1'b1);
    req_src = 32'h2;
    @(negedge clk);
    chk1("b2b_csr_read2", req_ready, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    chk1("b2b_csr_rdwen2", rd_wen, 1'b1);
    chk("b2b_csr_rdata2", rd_wdata, 32'h1);
    chk("b2b_csr_wdata2", csr_wdata, 32'h2);
    @(negedge clk);
    chk1("b2b_csr_done2", done_valid, 1'b1);
    @(negedge clk);
    chk("b2b_csr_mepc", csr[0], 32'h2);

    // Back-to-back ECALL then MRET: MRET sees the mepc ECALL just wrote.
    preload({32'h40, 32'h0, 32'h0, 32'h0});
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_pc = 32'h10;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk1($sformatf("b2b_trap_busy%0d", k), req_ready, 1'b0);
    end
    @(negedge clk);
    chk1("b2b_trap_ready3", req_ready, 1'b1);
    req_op = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk1("b2b_ret_redir", redir_valid, 1'b1);
    chk("b2b_ret_pc", redir_pc, 32'h10);
    @(negedge clk);
    chk1("b2b_ret_done", done_valid, 1'b1);
    @(negedge clk);

    // Reset raised in the WRITE cycle of a CSRRW.
    preload({32'h55, 32'h0, 32'h0, 32'h0});
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_csr = 2'd3; req_src = 32'haa;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk1("rstw_in_write", rd_wen, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rstw_csrwen_masked", csr_wen, 1'b0);
    chk1("rstw_rdwen_masked", rd_wen, 1'b0);
    @(negedge clk);
    chk1("rstw_after_ready", req_ready, 1'b1);
    chk1("rstw_after_done", done_valid, 1'b0);
    chk1("rstw_after_rdwen", rd_wen, 1'b0);
    chk("rstw_mtvec", csr[3], 32'h55);
    rst = 1'b0;
    @(negedge clk);
    chk1("rstw_idle_ready", req_ready, 1'b1);
    chk1("rstw_idle_done", done_valid, 1'b0);
    chk1("rstw_idle_csrwen", csr_wen, 1'b0);
    chk("rstw_mtvec2", csr[3], 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
